// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory port arbiter and its lane aligner.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Reserved size counts as misaligned so the access is rejected without touching memory.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables, store data replication, load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    be = 4'b1111;
    if (we) begin
      case (size)
        SZ_BYTE: be = 4'b0001 << addr_lo;
        SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Move the addressed lane(s) down to bit 0 before extending.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: rdata_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// with a starvation limit that forces a fetch grant after a run of data grants.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [1:0]            d_size,
  input  logic                  d_signed,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  state;
  logic [3:0]  starve_cnt;
  logic        grant_d;
  logic        grant_i;
  logic        d_bad;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // The data request stays stable until its ack, so the aligner can use it directly on both ends.
  mem_lane_align u_align (
    .size      (d_size),
    .addr_lo   (d_addr[1:0]),
    .we        (d_we),
    .sgn       (d_signed),
    .wdata     (d_wdata),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  assign grant_d = d_req && (!i_req || (starve_cnt < LIMIT));
  assign grant_i = !grant_d && i_req;
  assign d_bad   = size_misaligned(d_size, d_addr[1:0]);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      i_ack      <= 1'b0;
      i_rdata    <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            if (i_req && (starve_cnt < LIMIT)) starve_cnt <= starve_cnt + 4'd1;
            if (d_bad) begin
              state   <= RESP;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              state     <= BUSY_D;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= lane_be;
              mem_wdata <= lane_wdata;
            end
          end else if (grant_i) begin
            starve_cnt <= '0;
            state      <= BUSY_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be     <= 4'b1111;
            mem_wdata  <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            i_ack   <= 1'b1;
            i_rdata <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            d_ack   <= 1'b1;
            d_err   <= 1'b0;
            d_rdata <= mem_we ? 32'd0 : lane_rdata;
          end
        end
        RESP: begin
          state <= IDLE;
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench itself plays the memory model.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_signed;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_signed(d_signed), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one data request and acts as a one-wait-state memory; returns what was observed.
  task automatic run_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sgn, input logic [31:0] word,
                          output logic saw_req, output logic [31:0] got_addr, output logic [3:0] got_be,
                          output logic [31:0] got_wdata, output logic got_we, output logic ack_seen,
                          output logic [31:0] got_rdata, output logic got_err, output int cycles);
    d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_signed = sgn; d_req = 1'b1;
    saw_req = 1'b0; got_addr = '0; got_be = '0; got_wdata = '0; got_we = 1'b0; cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cycles++;
      if (mem_req || d_ack) break;
    end
    if (mem_req) begin
      saw_req = 1'b1; got_addr = mem_addr; got_be = mem_be; got_wdata = mem_wdata; got_we = mem_we;
      @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = word;
      @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
    end
    ack_seen = d_ack; got_rdata = d_rdata; got_err = d_err;
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_size = 0; d_signed = 0; mem_rdata = 0; mem_ack = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({i_ack, d_ack, d_err, mem_we} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags got %b exp 0000", {i_ack, d_ack, d_err, mem_we}); end
    checks++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'd0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, i_rdata, d_rdata}); end
    checks++; if (mem_be !== 4'b0) begin errors++; $display("[TB] FAIL reset_be got %b exp 0000", mem_be); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch;
    logic found;
    found = 1'b0;
    i_addr = 32'h40; i_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL fetch_req got %b exp 1", found); end
    checks++; if (mem_be !== 4'b1111) begin errors++; $display("[TB] FAIL fetch_be got %b exp 1111", mem_be); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL fetch_addr got %h exp 00000040", mem_addr); end
    @(posedge clk); #1;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (i_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_early_ack got %b exp 0", i_ack); end
    @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checks++; if (i_ack !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ack got %b exp 1", i_ack); end
    checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fetch_rdata got %h exp deadbeef", i_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_req_drop got %b exp 0", mem_req); end
    @(posedge clk); #1; i_req = 1'b0;
    @(negedge clk);
    checks++; if ({i_ack, busy} !== 2'b00) begin errors++; $display("[TB] FAIL fetch_idle got %b exp 00", {i_ack, busy}); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_loads;
    logic sr, we_o, ak, er; logic [31:0] a, wd, rd; logic [3:0] be; int cy;
    run_data(1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b1, 32'hFF000000, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if ({sr, ak, er} !== 3'b110) begin errors++; $display("[TB] FAIL lb_signed_hs got %b exp 110", {sr, ak, er}); end
    checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL lb_signed got %h exp ffffffff", rd); end
    checks++; if ({a, be, we_o} !== {32'h100, 4'b1111, 1'b0}) begin errors++; $display("[TB] FAIL lb_port got %h/%b/%b exp 00000100/1111/0", a, be, we_o); end
    checks++; if (cy !== 2) begin errors++; $display("[TB] FAIL lb_latency got %0d exp 2", cy); end
    run_data(1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b0, 32'hFF000000, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if (rd !== 32'h000000FF) begin errors++; $display("[TB] FAIL lbu got %h exp 000000ff", rd); end
    run_data(1'b0, 32'h101, 32'h0, SZ_BYTE, 1'b1, 32'h00007F00, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if (rd !== 32'h0000007F) begin errors++; $display("[TB] FAIL lb_pos got %h exp 0000007f", rd); end
    run_data(1'b0, 32'h102, 32'h0, SZ_HALF, 1'b1, 32'h80010000, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL lh_signed got %h exp ffff8001", rd); end
    run_data(1'b0, 32'h100, 32'h0, SZ_HALF, 1'b0, 32'h80018765, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if (rd !== 32'h00008765) begin errors++; $display("[TB] FAIL lhu got %h exp 00008765", rd); end
  endtask

  task automatic test_stores;
    logic sr, we_o, ak, er; logic [31:0] a, wd, rd; logic [3:0] be; int cy;
    run_data(1'b1, 32'h102, 32'h00001234, SZ_HALF, 1'b0, 32'h0, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if (a !== 32'h100) begin errors++; $display("[TB] FAIL sh_addr got %h exp 00000100", a); end
    checks++; if (be !== 4'b1100) begin errors++; $display("[TB] FAIL sh_be got %b exp 1100", be); end
    checks++; if (wd !== 32'h12341234) begin errors++; $display("[TB] FAIL sh_wdata got %h exp 12341234", wd); end
    checks++; if ({we_o, ak, er, rd} !== {3'b110, 32'h0}) begin errors++; $display("[TB] FAIL sh_resp got %b/%h exp 110/0", {we_o, ak, er}, rd); end
    run_data(1'b1, 32'h201, 32'hCAFE00AB, SZ_BYTE, 1'b0, 32'h0, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if ({be, wd} !== {4'b0010, 32'hABABABAB}) begin errors++; $display("[TB] FAIL sb got %b/%h exp 0010/abababab", be, wd); end
    run_data(1'b1, 32'h204, 32'h89ABCDEF, SZ_WORD, 1'b0, 32'h0, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if ({a, be, wd} !== {32'h204, 4'b1111, 32'h89ABCDEF}) begin errors++; $display("[TB] FAIL sw got %h/%b/%h exp 00000204/1111/89abcdef", a, be, wd); end
  endtask

  task automatic test_errors;
    logic sr, we_o, ak, er; logic [31:0] a, wd, rd; logic [3:0] be; int cy;
    run_data(1'b0, 32'h101, 32'h0, SZ_WORD, 1'b0, 32'h0, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if ({sr, ak, er} !== 3'b011) begin errors++; $display("[TB] FAIL err_word got %b exp 011", {sr, ak, er}); end
    checks++; if (cy !== 2) begin errors++; $display("[TB] FAIL err_latency got %0d exp 2", cy); end
    run_data(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 32'h0, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if ({sr, ak, er} !== 3'b011) begin errors++; $display("[TB] FAIL err_size got %b exp 011", {sr, ak, er}); end
    run_data(1'b1, 32'h103, 32'h0, SZ_HALF, 1'b0, 32'h0, sr, a, be, wd, we_o, ak, rd, er, cy);
    checks++; if ({sr, ak, er} !== 3'b011) begin errors++; $display("[TB] FAIL err_half got %b exp 011", {sr, ak, er}); end
  endtask

  task automatic test_fairness;
    logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic found;
    i_addr = 32'h80; i_req = 1'b1;
    d_addr = 32'h100; d_we = 1'b0; d_size = SZ_WORD; d_signed = 1'b0; d_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_req) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
        errors++; $display("[TB] FAIL fair_timeout grant %0d got none exp one", g);
        break;
      end
      if ((mem_addr == 32'h100) !== exp_d[g]) begin
        errors++; $display("[TB] FAIL fair_order grant %0d got data=%b exp data=%b", g, (mem_addr == 32'h100), exp_d[g]);
      end
      @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h11111111;
      @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = '0;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fair_drain got %b exp 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic found, stray;
    found = 1'b0; stray = 1'b0;
    d_addr = 32'h100; d_we = 1'b0; d_size = SZ_WORD; d_signed = 1'b0; d_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) begin found = 1'b1; break; end
    end
    checks++; if ({found, busy} !== 2'b11) begin errors++; $display("[TB] FAIL rmid_busy got %b exp 11", {found, busy}); end
    @(posedge clk); #1; rst = 1'b0; d_req = 1'b0;
    #1;
    checks++; if ({mem_req, busy, d_ack, mem_be, mem_addr} !== '0) begin errors++; $display("[TB] FAIL rmid_clear got %b/%b/%b/%b/%h exp all 0", mem_req, busy, d_ack, mem_be, mem_addr); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_ack || busy || mem_req) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL rmid_late_ack got %b exp 0", stray); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_loads();
    test_stores();
    test_errors();
    test_fairness();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
